keypad_entry: RTL and testbench
===============================

Name: keypad_entry

Overview:
- Input-side counterpart of the 4-digit 7-segment display path: scans a 4x4 hex matrix keypad, debounces it and assembles a 16-bit hex word.
- The word and cursor are shaped to drive the display's data and decimal-point-pointer inputs directly.
- Timing comes from the existing 1 ms clock-enable (ce1ms), so no extra dividers are needed.

Parameters:
- DEB_MS, 20, debounce time in ce1ms ticks for both press and release (legal range 1..255).
- REPEAT_MS, 500, hold time before auto-repeat starts and the auto-repeat period, in ce1ms ticks (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ce1ms  in  1  one-clk-wide enable, once per ms.
- clr  in  1  synchronous clear of the entered word.
- row  in  4  keypad rows, active-low, externally pulled up.
- col  out  4  keypad column drive, active-low, exactly one bit low.
- dat  out  16  entered hex word, newest digit in dat[3:0].
- ptr  out  2  index of the most-significant entered digit, for the decimal point.
- key_code  out  4  code of the last accepted key.
- key_valid  out  1  one-clk pulse per accepted key.

Behaviour:
- Reset (async, rst_n=0): col=4'b1110, column index 0, state SCAN, dat=0, ptr=0, key_code=0, key_valid=0, digit count cnt=0, debounce counter=0.
- All state changes happen on the clk rising edge. Timing counters advance only when ce1ms=1.
- Key code = row_index*4 + col_index. Row index r corresponds to the low row[r]; column index c to col[c]=0.
- SCAN:
  - On each ce1ms tick, if row==4'hF, rotate the low column bit 0->1->2->3->0.
  - If exactly one row bit is low on a tick, latch row and col, clear the counter and go to DEB_PRESS. The column stays frozen.
  - If two or more row bits are low, ignore it and keep rotating.
- DEB_PRESS:
  - On each tick, if row equals the latched pattern, increment the counter; otherwise return to SCAN with the counter cleared.
  - When the counter reaches DEB_MS, accept the key:
    - key_code <= code, key_valid=1 for exactly one clk.
    - dat <= {dat[11:0], code}.
    - cnt <= min(cnt+1, 4).
    - Go to HELD.
- HELD:
  - On each tick, if row==4'hF, clear the counter and go to DEB_REL. Otherwise stay.
- DEB_REL:
  - On each tick, if row==4'hF, increment the counter; any low row returns to HELD.
  - When the counter reaches DEB_MS, go to SCAN and resume rotation from the frozen column.
- ptr = 0 when cnt is 0 or 1; otherwise ptr = cnt-1, saturating at 3.
- clr=1: dat<=0 and cnt<=0 in the same cycle. clr has priority over a simultaneous key acceptance; that key's key_valid still pulses and key_code still updates, but dat stays 0. clr does not change the FSM state.
- After 4 digits have been entered, further keys keep shifting (the oldest digit drops out of dat[15:12]) and ptr stays at 3.
- Latency: key_valid asserts on the clk edge after the ce1ms tick on which the counter reaches DEB_MS. That is DEB_MS ticks after the first qualifying tick, plus 0..3 ticks for the scan to reach the column.
- A glitch shorter than DEB_MS ticks never produces key_valid.
- rst_n asserted in any state aborts immediately to the reset values. No pulse is emitted during or after reset.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - HELD runs a repeat counter on ce1ms ticks.
  - After REPEAT_MS ticks of continuous hold, the same key is re-accepted (key_valid pulse, shift into dat, cnt update), then again every REPEAT_MS ticks.
  - The repeat counter clears when entering HELD and after each repeat. Leaving HELD stops repeating.
- Undefined:
  - No repeat counter exists, and a held key produces exactly one key_valid.

Test Plan:
- Reset, no keys, 8 ce1ms ticks -> col sequence 1110,1101,1011,0111,1110,...; dat=0, ptr=0, key_valid never 1.
- Hold row[1] low while col[2] is driven (key 6) for 25 ticks with DEB_MS=20 -> exactly one key_valid, key_code=6, dat=16'h0006, ptr=0; col frozen at 1011 until release is debounced.
- Press 1,2,3,4,5 in sequence, each held 25 ticks with 25-tick releases -> dat=16'h2345, ptr=3, five key_valid pulses.
- Row bounce: low for 5 ticks, high for 1, repeated -> no key_valid, FSM returns to SCAN. Two rows low at once -> ignored, scanning continues.
- clr pulsed on the same clk as a key acceptance with dat=16'h00AB -> dat=0, cnt=0, ptr=0, key_valid=1, key_code updated.
- Assert rst_n=0 mid-DEB_PRESS -> all outputs at reset values immediately, with no key_valid. With KEYPAD_AUTOREPEAT_EN, REPEAT_MS=50 and key F held for 170 ticks -> 1+2 key_valid pulses and dat=16'h0FFF.

Source files
------------

// File: rtl/keypad_entry_if.sv
// keypad_entry_if: keypad scan pins plus the entered-word / key-event outputs.
// master = the side that drives the keypad rows and timing (board / bench),
// slave  = keypad_entry itself.
interface keypad_entry_if;
    logic        ce1ms;
    logic        clr;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] dat;
    logic [1:0]  ptr;
    logic [3:0]  key_code;
    logic        key_valid;

    modport master (
        output ce1ms, clr, row,
        input  col, dat, ptr, key_code, key_valid
    );

    modport slave (
        input  ce1ms, clr, row,
        output col, dat, ptr, key_code, key_valid
    );
endinterface

// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 hex keypad scanner with debounce, assembling a 16-bit hex
// word (newest digit in dat[3:0]) and a decimal-point pointer for the display.
// All timing runs off the 1 ms clock enable ce1ms.
// Optional build macro KEYPAD_AUTOREPEAT_EN: a held key is re-accepted every
// REPEAT_MS ticks after an initial REPEAT_MS hold.
//
// state     | meaning
// ----------+------------------------------------------------------------
// SCAN      | rotating the low column each tick, looking for one low row
// DEB_PRESS | column frozen, counting ticks the latched row stays stable
// HELD      | key accepted, waiting for all rows high (optionally repeating)
// DEB_REL   | counting ticks of all rows high before scanning resumes
module keypad_entry #(
    parameter int DEB_MS    = 20,
    parameter int REPEAT_MS = 500
) (
    input  logic           clk,
    input  logic           rst_n,
    keypad_entry_if.slave  kp
);

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

    localparam logic [7:0] DEB_TC = 8'(DEB_MS);

    // Elaboration-time guard against parameter values the counters cannot hold.
    if (DEB_MS < 1 || DEB_MS > 255 || REPEAT_MS < 1) begin : g_bad_param
        $error("keypad_entry: DEB_MS must be 1..255 and REPEAT_MS >= 1");
    end

    state_t      state, state_nxt;
    logic [1:0]  col_idx, col_idx_nxt;
    logic [3:0]  row_lat, row_lat_nxt;
    logic [7:0]  deb_cnt, deb_cnt_nxt;
    logic [7:0]  deb_inc;
    logic        one_low;
    logic        accept;
    logic [1:0]  row_idx;
    logic [3:0]  code;

    logic [15:0] dat_q;
    logic [2:0]  cnt;
    logic [3:0]  key_code_q;
    logic        key_valid_q;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = (REPEAT_MS > 1) ? $clog2(REPEAT_MS + 1) : 1;
    localparam logic [REP_W-1:0] REP_TC = REP_W'(REPEAT_MS);
    logic [REP_W-1:0] rep_cnt, rep_cnt_nxt, rep_inc;
    assign rep_inc = rep_cnt + 1'b1;
`endif

    assign deb_inc = deb_cnt + 8'd1;
    assign one_low = (kp.row == 4'b1110) || (kp.row == 4'b1101) ||
                     (kp.row == 4'b1011) || (kp.row == 4'b0111);

    // Row index of the latched single-low row pattern.
    always_comb begin
        row_idx = 2'd3;
        case (row_lat)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            default: row_idx = 2'd3;
        endcase
    end

    assign code = {row_idx, col_idx};

    // Next-state logic: scan, debounce press/release, detect acceptance.
    always_comb begin
        state_nxt   = state;
        col_idx_nxt = col_idx;
        row_lat_nxt = row_lat;
        deb_cnt_nxt = deb_cnt;
        accept      = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_nxt = rep_cnt;
`endif
        if (kp.ce1ms) begin
            case (state)
                SCAN: begin
                    if (one_low) begin
                        row_lat_nxt = kp.row;
                        deb_cnt_nxt = 8'd0;
                        state_nxt   = DEB_PRESS;
                    end else begin
                        // Idle or multi-key chords both just keep rotating.
                        col_idx_nxt = col_idx + 2'd1;
                    end
                end
                DEB_PRESS: begin
                    if (kp.row == row_lat) begin
                        deb_cnt_nxt = deb_inc;
                        if (deb_inc == DEB_TC) begin
                            accept      = 1'b1;
                            deb_cnt_nxt = 8'd0;
                            state_nxt   = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_cnt_nxt = '0;
`endif
                        end
                    end else begin
                        deb_cnt_nxt = 8'd0;
                        state_nxt   = SCAN;
                    end
                end
                HELD: begin
                    if (kp.row == 4'hF) begin
                        deb_cnt_nxt = 8'd0;
                        state_nxt   = DEB_REL;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (rep_inc == REP_TC) begin
                        accept      = 1'b1;
                        rep_cnt_nxt = '0;
                    end else begin
                        rep_cnt_nxt = rep_inc;
                    end
`endif
                end
                DEB_REL: begin
                    if (kp.row == 4'hF) begin
                        deb_cnt_nxt = deb_inc;
                        if (deb_inc == DEB_TC) begin
                            deb_cnt_nxt = 8'd0;
                            state_nxt   = SCAN;
                        end
                    end else begin
                        state_nxt = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_cnt_nxt = '0;
`endif
                    end
                end
                default: state_nxt = SCAN;
            endcase
        end
    end

    // FSM and scan/debounce registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SCAN;
            col_idx <= 2'd0;
            row_lat <= 4'hF;
            deb_cnt <= 8'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
        end else begin
            state   <= state_nxt;
            col_idx <= col_idx_nxt;
            row_lat <= row_lat_nxt;
            deb_cnt <= deb_cnt_nxt;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt <= rep_cnt_nxt;
`endif
        end
    end

    // Entered word, digit count and key event; clr wins over a same-cycle key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_q       <= 16'h0000;
            cnt         <= 3'd0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            key_valid_q <= accept;
            if (accept) begin
                key_code_q <= code;
                dat_q      <= {dat_q[11:0], code};
                cnt        <= (cnt == 3'd4) ? 3'd4 : cnt + 3'd1;
            end
            if (kp.clr) begin
                dat_q <= 16'h0000;
                cnt   <= 3'd0;
            end
        end
    end

    assign kp.col       = ~(4'b0001 << col_idx);
    assign kp.dat       = dat_q;
    assign kp.ptr       = (cnt < 3'd2) ? 2'd0 : 2'(cnt - 3'd1);
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: emulates a physical 4x4 keypad against keypad_entry and
// checks every cycle against a tick-level behavioural model of the keypad
// entry rules, plus directed literal expectations from the test plan.
module tb_keypad_entry;

    localparam int DEB = 20;
    localparam int REP = 50;

    localparam int PH_SCAN  = 0;
    localparam int PH_PRESS = 1;
    localparam int PH_HELD  = 2;
    localparam int PH_REL   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_entry_if kp ();

    keypad_entry #(.DEB_MS(DEB), .REPEAT_MS(REP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp)
    );

    int checks = 0;
    int failures = 0;
    int pulses = 0;

    // keypad stimulus: bit k set means key k is physically pressed
    logic [15:0] keys = 16'h0000;
    bit force_clr = 0;
    bit rand_clr = 0;
    bit clr_on_accept = 0;
    bit clr_hit = 0;
    int gap_lo = 2;
    int gap_hi = 2;

    // behavioural model state
    int          m_col;
    int          m_phase;
    int          m_ticks;
    int          m_rep;
    logic [3:0]  m_lat;
    int          m_word;
    int          m_cnt;
    int          m_code;
    bit          m_valid;

    logic [3:0] col_seq [0:7] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110,
                                  4'b1101, 4'b1011, 4'b0111, 4'b1110};

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_col = 0; m_phase = PH_SCAN; m_ticks = 0; m_rep = 0; m_lat = 4'hF;
        m_word = 0; m_cnt = 0; m_code = 0; m_valid = 0;
    endfunction

    function automatic logic [3:0] keypad_row(logic [15:0] k, int c);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 4; i++)
            if (k[i*4 + c]) r[i] = 1'b0;
        return r;
    endfunction

    function automatic int zeros(logic [3:0] r);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) if (!r[i]) n++;
        return n;
    endfunction

    function automatic int low_index(logic [3:0] r);
        int idx;
        idx = 0;
        for (int i = 0; i < 4; i++) if (!r[i]) idx = i;
        return idx;
    endfunction

    function automatic bit model_tick(logic [3:0] r);
        bit acc;
        acc = 0;
        if (m_phase == PH_SCAN) begin
            if (zeros(r) == 1) begin
                m_lat = r; m_ticks = 0; m_phase = PH_PRESS;
            end else begin
                m_col = (m_col + 1) % 4;
            end
        end else if (m_phase == PH_PRESS) begin
            if (r == m_lat) begin
                m_ticks++;
                if (m_ticks == DEB) begin acc = 1; m_phase = PH_HELD; m_rep = 0; end
            end else begin
                m_ticks = 0; m_phase = PH_SCAN;
            end
        end else if (m_phase == PH_HELD) begin
            if (r == 4'hF) begin
                m_ticks = 0; m_phase = PH_REL;
            end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                m_rep++;
                if (m_rep == REP) begin acc = 1; m_rep = 0; end
`endif
            end
        end else begin
            if (r == 4'hF) begin
                m_ticks++;
                if (m_ticks == DEB) m_phase = PH_SCAN;
            end else begin
                m_phase = PH_HELD; m_rep = 0;
            end
        end
        if (acc) begin
            m_code = low_index(m_lat) * 4 + m_col;
            m_word = (m_word * 16 + m_code) % 65536;
            if (m_cnt < 4) m_cnt++;
        end
        return acc;
    endfunction

    // one clk: drive inputs at negedge and advance the model to the post-edge state
    task automatic one_clk(input bit ce);
        logic [3:0] r;
        bit acc;
        bit c;
        @(negedge clk);
        r = keypad_row(keys, m_col);
        c = force_clr || (rand_clr && ($urandom_range(0, 63) == 0));
        acc = 0;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (ce) acc = model_tick(r);
            if (clr_on_accept && acc) begin c = 1; clr_hit = 1; end
            m_valid = acc;
            if (c) begin m_word = 0; m_cnt = 0; end
        end
        kp.ce1ms = ce;
        kp.row   = r;
        kp.clr   = c;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            one_clk(1'b1);
            repeat ($urandom_range(gap_lo, gap_hi)) one_clk(1'b0);
        end
    endtask

    task automatic press(input int k, input int hold, input int rel);
        keys = 16'h0000;
        keys[k] = 1'b1;
        ticks(hold);
        keys = 16'h0000;
        ticks(rel);
    endtask

    // per-cycle compare against the model, sampled after the active edge
    always @(posedge clk) begin
        #1;
        if (kp.key_valid === 1'b1) pulses++;
        if (rst_n) begin
            check("col", int'(kp.col), int'(4'hF ^ (4'b0001 << m_col)));
            check("dat", int'(kp.dat), m_word);
            check("ptr", int'(kp.ptr), (m_cnt < 2) ? 0 : m_cnt - 1);
            check("key_code", int'(kp.key_code), m_code);
            check("key_valid", int'(kp.key_valid), int'(m_valid));
        end
    end

    initial begin
        kp.ce1ms = 1'b0;
        kp.clr   = 1'b0;
        kp.row   = 4'hF;
        model_reset();
        repeat (3) one_clk(1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // reset values and idle rotation
        check("rst_col", int'(kp.col), 4'he);
        check("rst_dat", int'(kp.dat), 0);
        check("rst_ptr", int'(kp.ptr), 0);
        check("rst_key_code", int'(kp.key_code), 0);
        check("rst_key_valid", int'(kp.key_valid), 0);
        for (int i = 0; i < 8; i++) begin
            ticks(1);
            check("idle_col_seq", int'(kp.col), int'(col_seq[i]));
        end
        check("idle_pulses", pulses, 0);

        // key 6: row 1, column 2
        pulses = 0;
        keys = 16'h0040;
        ticks(25);
        check("k6_col_frozen", int'(kp.col), 4'b1011);
        keys = 16'h0000;
        ticks(5);
        check("k6_col_rel_frozen", int'(kp.col), 4'b1011);
        ticks(20);
        check("k6_pulses", pulses, 1);
        check("k6_code", int'(kp.key_code), 6);
        check("k6_dat", int'(kp.dat), 16'h0006);
        check("k6_ptr", int'(kp.ptr), 0);

        // five keys in a row
        pulses = 0;
        for (int k = 1; k <= 5; k++) press(k, 25, 25);
        check("seq_pulses", pulses, 5);
        check("seq_dat", int'(kp.dat), 16'h2345);
        check("seq_ptr", int'(kp.ptr), 3);

        // bouncing row, then a two-row chord
        pulses = 0;
        repeat (6) begin
            keys = 16'h0200; ticks(5);
            keys = 16'h0000; ticks(1);
        end
        ticks(4);
        keys = 16'h0022;
        ticks(30);
        keys = 16'h0000;
        ticks(4);
        check("glitch_pulses", pulses, 0);

        // clr colliding with a key acceptance
        force_clr = 1; one_clk(1'b0); force_clr = 0;
        press(10, 25, 25);
        press(11, 25, 25);
        check("ab_dat", int'(kp.dat), 16'h00ab);
        pulses = 0;
        clr_hit = 0;
        clr_on_accept = 1;
        press(12, 25, 25);
        clr_on_accept = 0;
        check("clr_hit", int'(clr_hit), 1);
        check("clr_dat", int'(kp.dat), 0);
        check("clr_ptr", int'(kp.ptr), 0);
        check("clr_key_code", int'(kp.key_code), 12);
        check("clr_pulses", pulses, 1);

        // long hold of key F
        force_clr = 1; one_clk(1'b0); force_clr = 0;
        pulses = 0;
        press(15, 170, 25);
`ifdef KEYPAD_AUTOREPEAT_EN
        check("hold_pulses", pulses, 3);
        check("hold_dat", int'(kp.dat), 16'h0fff);
`else
        check("hold_pulses", pulses, 1);
        check("hold_dat", int'(kp.dat), 16'h000f);
`endif

        // asynchronous reset in the middle of a press debounce
        keys = 16'h0001;
        ticks(10);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_col", int'(kp.col), 4'he);
        check("arst_dat", int'(kp.dat), 0);
        check("arst_ptr", int'(kp.ptr), 0);
        check("arst_key_code", int'(kp.key_code), 0);
        check("arst_key_valid", int'(kp.key_valid), 0);
        model_reset();
        keys = 16'h0000;
        pulses = 0;
        repeat (3) one_clk(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        ticks(5);
        check("arst_pulses", pulses, 0);

        // randomized keypad activity with random tick spacing and clears
        gap_lo = 1;
        gap_hi = 3;
        rand_clr = 1;
        for (int s = 0; s < 60; s++) begin
            int kind;
            kind = $urandom_range(0, 5);
            if (kind == 0) begin
                keys = 16'h0000;
                ticks($urandom_range(1, 30));
            end else if (kind == 1) begin
                keys = 16'h0000;
                keys[$urandom_range(0, 15)] = 1'b1;
                keys[$urandom_range(0, 15)] = 1'b1;
                ticks($urandom_range(1, 30));
            end else if (kind == 2) begin
                int k;
                k = $urandom_range(0, 15);
                repeat ($urandom_range(1, 4)) begin
                    keys = 16'h0000; keys[k] = 1'b1;
                    ticks($urandom_range(1, DEB - 1));
                    keys = 16'h0000;
                    ticks($urandom_range(1, 3));
                end
            end else begin
                press($urandom_range(0, 15), $urandom_range(1, 80), $urandom_range(1, 40));
            end
        end
        rand_clr = 0;
        keys = 16'h0000;
        ticks(30);

        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
